// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared state encoding and RAM geometry for ram_dma
package ram_dma_pkg;

   localparam int DEF_DW = 16;
   localparam int DEF_AW = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ram_dma.sv
// rtl/ram_dma.sv - block copy engine on the single-port data RAM port
// Optional fill mode is built only when RAM_DMA_FILL_EN is defined.
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic          fill,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dout
);

   state_t        state, state_n;
   logic [AW-1:0] src_q, src_n;
   logic [AW-1:0] dst_q, dst_n;
   logic [AW-1:0] cnt_q, cnt_n;
   logic [AW-1:0] addr_n;
   logic          we_n;
   logic          fill_mode;
   logic          start_fill;

`ifdef RAM_DMA_FILL_EN
   logic          fill_q, fill_n;
   logic [DW-1:0] fval_q, fval_n;

   always_comb begin
      fill_n = fill_q;
      fval_n = fval_q;
      if (state == IDLE && start) begin
         fill_n = fill;
         fval_n = fill_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= 1'b0;
         fval_q <= '0;
      end else begin
         fill_q <= fill_n;
         fval_q <= fval_n;
      end
   end

   assign fill_mode  = fill_q;
   assign start_fill = fill;
   assign mem_din    = fill_q ? fval_q : mem_dout;
`else
   logic unused_fill;
   assign unused_fill = ^{fill, fill_val};
   assign fill_mode   = 1'b0;
   assign start_fill  = 1'b0;
   assign mem_din     = mem_dout;
`endif

   always_comb begin
      state_n = state;
      src_n   = src_q;
      dst_n   = dst_q;
      cnt_n   = cnt_q;
      case (state)
         IDLE: begin
            if (start) begin
               src_n = src;
               dst_n = dst;
               cnt_n = len;
               if (len == '0)
                  state_n = DONE;
               else if (start_fill)
                  state_n = WR;
               else
                  state_n = RD;
            end
         end
         RD: state_n = WR;
         WR: begin
            src_n = src_q + AW'(1);
            dst_n = dst_q + AW'(1);
            cnt_n = cnt_q - AW'(1);
            if (cnt_q == AW'(1))
               state_n = DONE;
            else if (fill_mode)
               state_n = WR;
            else
               state_n = RD;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Address and write enable are registered, so they are derived from the next state
   always_comb begin
      we_n   = (state_n == WR);
      addr_n = mem_addr;
      if (state_n == RD)
         addr_n = src_n;
      else if (state_n == WR)
         addr_n = dst_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         mem_addr <= '0;
         mem_we   <= 1'b0;
      end else begin
         state    <= state_n;
         src_q    <= src_n;
         dst_q    <= dst_n;
         cnt_q    <= cnt_n;
         mem_addr <= addr_n;
         mem_we   <= we_n;
      end
   end

   assign busy = (state == RD) || (state == WR);
   assign done = (state == DONE);

endmodule

// File: tb/tb_ram_dma.sv
// tb/tb_ram_dma.sv - directed self-checking bench for ram_dma with a behavioural RAM
module tb_ram_dma;
   import ram_dma_pkg::*;

   localparam int DW = DEF_DW;
   localparam int AW = DEF_AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] src = '0, dst = '0, len = '0;
   logic          fill = 1'b0;
   logic [DW-1:0] fill_val = '0;
   logic          busy, done, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [AW-1:0] raddr = '0;
   logic          pl_we = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   int n_checks = 0;
   int n_pass   = 0;
   int busy_cnt, we_cnt, done_cyc;
   logic [AW-1:0] rd_q[$];
   logic [AW-1:0] wr_q[$];

   always #5 clk = ~clk;

   ram_dma dut (
      .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
      .fill(fill), .fill_val(fill_val), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
   );

   // RAM keeps its registered read address while we=1
   always @(posedge clk) begin
      if (pl_we)
         ram[pl_addr] <= pl_data;
      else if (mem_we)
         ram[mem_addr] <= mem_din;
      else
         raddr <= mem_addr;
   end
   assign mem_dout = ram[raddr];

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW-1:0] l, input logic f, input logic [DW-1:0] fv);
      @(negedge clk);
      src = s; dst = d; len = l; fill = f; fill_val = fv; start = 1'b1;
      @(negedge clk);
      start = 1'b0; fill = 1'b0;
      busy_cnt = 0; we_cnt = 0; done_cyc = 0;
      rd_q.delete(); wr_q.delete();
      for (int c = 1; c <= 100; c++) begin
         if (done) begin
            done_cyc = c;
            break;
         end
         if (busy) busy_cnt++;
         if (mem_we) begin
            we_cnt++;
            wr_q.push_back(mem_addr);
         end else if (busy) begin
            rd_q.push_back(mem_addr);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", mem_we); else n_pass++;
      n_checks++; if (mem_addr !== '0) $display("FAIL reset_addr got %h want 0", mem_addr); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_copy;
      for (int i = 0; i < 4; i++) begin
         poke(AW'(13'h10 + i), DW'(16'hA001 + i));
         poke(AW'(13'h40 + i), 16'h0000);
      end
      run_xfer(13'h10, 13'h40, 13'd4, 1'b0, 16'h0);
      n_checks++; if (busy_cnt != 8) $display("FAIL copy_busy_cycles got %0d want 8", busy_cnt); else n_pass++;
      n_checks++; if (done_cyc != 9) $display("FAIL copy_done_cycle got %0d want 9", done_cyc); else n_pass++;
      n_checks++; if (we_cnt != 4) $display("FAIL copy_writes got %0d want 4", we_cnt); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ram[13'h40 + i] !== DW'(16'hA001 + i))
            $display("FAIL copy_data[%0d] got %h want %h", i, ram[13'h40 + i], DW'(16'hA001 + i));
         else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL copy_done_width got %b want 0", done); else n_pass++;
   endtask

   task automatic test_len_zero;
      run_xfer(13'h10, 13'h50, 13'd0, 1'b0, 16'h0);
      n_checks++; if (done_cyc != 1) $display("FAIL len0_done_cycle got %0d want 1", done_cyc); else n_pass++;
      n_checks++; if (busy_cnt != 0) $display("FAIL len0_busy got %0d want 0", busy_cnt); else n_pass++;
      n_checks++; if (we_cnt != 0 || mem_we !== 1'b0) $display("FAIL len0_we got %0d want 0", we_cnt); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_wrap;
      logic [AW-1:0] exp_rd [3];
      exp_rd[0] = 13'h1FFE; exp_rd[1] = 13'h1FFF; exp_rd[2] = 13'h0000;
      for (int i = 0; i < 3; i++) poke(exp_rd[i], DW'(16'hC000 + i));
      run_xfer(13'h1FFE, 13'h0100, 13'd3, 1'b0, 16'h0);
      n_checks++; if (rd_q.size() != 3 || wr_q.size() != 3)
         $display("FAIL wrap_access_count got rd=%0d wr=%0d want 3/3", rd_q.size(), wr_q.size());
      else n_pass++;
      for (int i = 0; i < 3 && i < rd_q.size() && i < wr_q.size(); i++) begin
         n_checks++; if (rd_q[i] !== exp_rd[i])
            $display("FAIL wrap_rd_addr[%0d] got %h want %h", i, rd_q[i], exp_rd[i]); else n_pass++;
         n_checks++; if (wr_q[i] !== AW'(13'h100 + i))
            $display("FAIL wrap_wr_addr[%0d] got %h want %h", i, wr_q[i], AW'(13'h100 + i)); else n_pass++;
         n_checks++; if (ram[13'h100 + i] !== DW'(16'hC000 + i))
            $display("FAIL wrap_data[%0d] got %h want %h", i, ram[13'h100 + i], DW'(16'hC000 + i)); else n_pass++;
      end
      @(negedge clk);
   endtask

   task automatic test_overlap;
      poke(13'h20, 16'h5555);
      for (int i = 1; i < 4; i++) poke(AW'(13'h20 + i), DW'(16'h1110 + i));
      run_xfer(13'h20, 13'h21, 13'd3, 1'b0, 16'h0);
      for (int i = 1; i < 4; i++) begin
         n_checks++; if (ram[13'h20 + i] !== 16'h5555)
            $display("FAIL overlap_data[%0d] got %h want 5555", i, ram[13'h20 + i]); else n_pass++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic saw_done;
      for (int i = 0; i < 8; i++) begin
         poke(AW'(13'h200 + i), DW'(16'h2200 + i));
         poke(AW'(13'h300 + i), 16'h0000);
      end
      @(negedge clk);
      src = 13'h200; dst = 13'h300; len = 13'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL midrst_we got %b want 0", mem_we); else n_pass++;
      saw_done = done;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done got %b want 0", saw_done); else n_pass++;
      n_checks++; if (ram[13'h300] !== 16'h2200) $display("FAIL midrst_word0 got %h want 2200", ram[13'h300]); else n_pass++;
      n_checks++; if (ram[13'h301] !== 16'h0000) $display("FAIL midrst_word1 got %h want 0000", ram[13'h301]); else n_pass++;
      run_xfer(13'h200, 13'h300, 13'd2, 1'b0, 16'h0);
      n_checks++; if (done_cyc != 5) $display("FAIL midrst_restart_done got %0d want 5", done_cyc); else n_pass++;
      n_checks++; if (ram[13'h301] !== 16'h2201) $display("FAIL midrst_restart_data got %h want 2201", ram[13'h301]); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_fill;
      logic [DW-1:0] exp_w;
      int            exp_busy;
      for (int i = 0; i < 5; i++) begin
         poke(AW'(13'h60 + i), DW'(16'h6000 + i));
         poke(AW'(13'h80 + i), 16'h0000);
      end
      run_xfer(13'h60, 13'h80, 13'd5, 1'b1, 16'hBEEF);
`ifdef RAM_DMA_FILL_EN
      exp_busy = 5;
`else
      exp_busy = 10;
`endif
      n_checks++; if (busy_cnt != exp_busy) $display("FAIL fill_busy got %0d want %0d", busy_cnt, exp_busy); else n_pass++;
      n_checks++; if (done_cyc != exp_busy + 1) $display("FAIL fill_done_cycle got %0d want %0d", done_cyc, exp_busy + 1); else n_pass++;
      for (int i = 0; i < 5; i++) begin
`ifdef RAM_DMA_FILL_EN
         exp_w = 16'hBEEF;
`else
         exp_w = DW'(16'h6000 + i);
`endif
         n_checks++; if (ram[13'h80 + i] !== exp_w)
            $display("FAIL fill_data[%0d] got %h want %h", i, ram[13'h80 + i], exp_w); else n_pass++;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_copy;
      test_len_zero;
      test_wrap;
      test_overlap;
      test_reset_mid;
      test_fill;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-copy engine that acts as the initiator on the single-port synchronous-read data RAM port (din/addr/we/dout). It sits beside the CPU and, on a start pulse, copies `len` words from `src` to `dst` inside the RAM, then pulses `done`. It issues one read per word, then one write per word, and relies on the RAM holding its registered read address during write cycles.

## Interface
- `DW`, 16, data width; must match the RAM's `DW`.
- `AW`, 13, address width; must match the RAM's `AW`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src`  in  AW  source start address; sampled with `start`.
- `dst`  in  AW  destination start address; sampled with `start`.
- `len`  in  AW  word count; sampled with `start`.
- `fill`  in  1  selects fill mode; only honoured with the macro (see Configuration).
- `fill_val`  in  DW  fill word; sampled with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  AW  drives RAM `addr`.
- `mem_din`  out  DW  drives RAM `din`.
- `mem_we`  out  1  drives RAM `we`.
- `mem_dout`  in  DW  from RAM `dout`.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: `start`=1 latches `src`, `dst`, `len`, `fill_val` and the mode.
  - If `len`=0, next state is DONE.
  - Otherwise copy goes to RD and fill goes to WR.
  - `start`=0 keeps the block in IDLE.
- RD: `mem_addr`=src pointer, `mem_we`=0. Next state is WR. The RAM registers the address on this edge.
- WR: `mem_addr`=dst pointer, `mem_we`=1.
  - Copy: `mem_din`=`mem_dout`. This value is stable because the RAM address register holds while `we`=1.
  - Pointers +1, remaining count −1.
  - If the count reaches 0, next state is DONE. Otherwise copy goes to RD and fill stays in WR.
- DONE: `done`=1, `busy`=0, `mem_we`=0. Next state is IDLE.
- `busy`=1 exactly in RD and WR.
- `start` outside IDLE is ignored; it is not queued.
- Pointers wrap modulo 2^AW. 0x1FFF+1 → 0x0000.
- Copy order is strictly ascending, one read then one write per word. With overlapping ranges, the result is whatever that order produces. For example, dst=src+1 replicates word src through the whole range.
- `mem_addr`, `mem_we` and the state are registered.
- `mem_din` is combinational: it equals the latched `fill_val` when fill mode is active, and `mem_dout` otherwise.
- Reset values: state IDLE, `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, pointers and count 0, fill mode inactive.
- Reset mid-transfer goes straight to IDLE with no `done` pulse. Words already written stay written. The first cycle after the reset edge has `mem_we`=0.

## Timing
- Edge E0 samples `start`.
- Copy of N≥1 words:
  - RD for word k in the cycle after E(2k); WR for word k in the cycle after E(2k+1).
  - DONE in the cycle after E(2N); `busy` is high after E0 through E(2N−1).
  - Total: 2N busy cycles, then 1 `done` cycle.
- Fill of N≥1 words: WR every cycle after E0..E(N−1). DONE follows after E(N).
- `len`=0: `done` in the cycle after E0, no memory access, `busy` never high.
- Earliest next accepted `start` is in the DONE cycle +1, i.e. back in IDLE.

## Configuration
- `RAM_DMA_FILL_EN` defined:
  - `fill`=1 at start runs fill mode: writes `fill_val` to dst..dst+len−1 at 1 word/cycle, with no reads.
- Not defined:
  - `fill` and `fill_val` ports remain but are ignored.
  - Every transfer is a copy; no fill-mode logic is built.

## Structure
- Shared package holds:
  - state encoding constants (IDLE=0, RD=1, WR=2, DONE=3);
  - default `DW`=16 / `AW`=13, shared with the RAM.
- Single module. One FSM plus pointer/count registers; no sub-module is warranted.
- Bench instantiates `ram_dma` connected to the existing RAM.

## Test plan
- Preload RAM[0x10..0x13]=0xA001..0xA004; start src=0x10, dst=0x40, len=4 → RAM[0x40..0x43]=0xA001..0xA004. `busy` is high for 8 cycles, then `done` pulses for 1 cycle.
- len=0 start → `done` in the cycle after E0, `mem_we` never 1, `busy` never 1.
- src=0x1FFE, dst=0x0100, len=3 → reads 0x1FFE, 0x1FFF, 0x0000 (wrap); writes 0x0100..0x0102.
- Overlap with RAM[0x20]=0x5555, src=0x20, dst=0x21, len=3 → RAM[0x21..0x23]=0x5555.
- Assert `rst` in the 3rd busy cycle of a len=8 copy → IDLE next cycle, `mem_we`=0, no `done`. A new start then completes normally.
- With `RAM_DMA_FILL_EN`: fill=1, fill_val=0xBEEF, dst=0x80, len=5 → RAM[0x80..0x84]=0xBEEF over 5 `busy` cycles. Without the macro, the same stimulus performs a copy.
